// File: rtl/keycode_packer.sv
// keycode_packer: turns PS/2 set-2 scancodes into terminal byte sequences
// (ASCII or VT100 escapes) and writes one packed entry per key press into
// the UART FIFO. It also tracks the shift, ctrl and caps-lock state.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   scanValid/Code     1-cycle strobe plus PS/2 byte, including E0/F0 prefixes
//   fifoFull           UART FIFO full; holds a pending entry
//   fifoWriteRequest   write strobe, combinational: high in EMIT while not full
//   fifoInData         {length[63:56], char1[55:48], ..., char7[7:0]}
//                      char[length] is sent first and char1 is sent last
//   capsLed            caps-lock state
//   droppedCount       saturating count of bytes discarded while an entry is pending
module keycode_packer #(
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scanValid,
  input  logic [7:0]            scanCode,
  input  logic                  fifoFull,
  output logic                  fifoWriteRequest,
  output logic [63:0]           fifoInData,
  output logic                  capsLed,
  output logic [DROP_CNT_W-1:0] droppedCount
);

  localparam int unsigned ENTRY_W = 64;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_DEL    = 8'h71;

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  logic [2:0]            state_q, state_d;
  logic                  shift_q, shift_d;
  logic                  ctrl_q, ctrl_d;
  logic                  caps_q, caps_d;
  logic [ENTRY_W-1:0]    entry_q, entry_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic [7:0]  letter_c;   // lowercase ASCII, 0 = not a letter
  logic [15:0] sym_c;      // {shifted, unshifted}, 0 = not a symbol key
  logic [7:0]  plain_c;    // space/enter/bs/tab/esc, 0 = none
  logic [7:0]  fkey_c;     // final byte of ESC O x, 0 = none
  logic [7:0]  ext_c;      // final byte of ESC [ x, 0 = none
  logic [7:0]  single_chr; // resolved single-byte character, 0 = unmapped
  logic        write_c;

  // Scancode lookup tables (US layout)
  always_comb begin
    letter_c = 8'h00;
    sym_c    = 16'h0000;
    plain_c  = 8'h00;
    fkey_c   = 8'h00;
    ext_c    = 8'h00;
    case (scanCode)
      8'h1C: letter_c = 8'h61;  8'h32: letter_c = 8'h62;  8'h21: letter_c = 8'h63;
      8'h23: letter_c = 8'h64;  8'h24: letter_c = 8'h65;  8'h2B: letter_c = 8'h66;
      8'h34: letter_c = 8'h67;  8'h33: letter_c = 8'h68;  8'h43: letter_c = 8'h69;
      8'h3B: letter_c = 8'h6A;  8'h42: letter_c = 8'h6B;  8'h4B: letter_c = 8'h6C;
      8'h3A: letter_c = 8'h6D;  8'h31: letter_c = 8'h6E;  8'h44: letter_c = 8'h6F;
      8'h4D: letter_c = 8'h70;  8'h15: letter_c = 8'h71;  8'h2D: letter_c = 8'h72;
      8'h1B: letter_c = 8'h73;  8'h2C: letter_c = 8'h74;  8'h3C: letter_c = 8'h75;
      8'h2A: letter_c = 8'h76;  8'h1D: letter_c = 8'h77;  8'h22: letter_c = 8'h78;
      8'h35: letter_c = 8'h79;  8'h1A: letter_c = 8'h7A;
      8'h16: sym_c = 16'h2131;  8'h1E: sym_c = 16'h4032;  8'h26: sym_c = 16'h2333;
      8'h25: sym_c = 16'h2434;  8'h2E: sym_c = 16'h2535;  8'h36: sym_c = 16'h5E36;
      8'h3D: sym_c = 16'h2637;  8'h3E: sym_c = 16'h2A38;  8'h46: sym_c = 16'h2839;
      8'h45: sym_c = 16'h2930;  8'h0E: sym_c = 16'h7E60;  8'h4E: sym_c = 16'h5F2D;
      8'h55: sym_c = 16'h2B3D;  8'h54: sym_c = 16'h7B5B;  8'h5B: sym_c = 16'h7D5D;
      8'h5D: sym_c = 16'h7C5C;  8'h4C: sym_c = 16'h3A3B;  8'h52: sym_c = 16'h2227;
      8'h41: sym_c = 16'h3C2C;  8'h49: sym_c = 16'h3E2E;  8'h4A: sym_c = 16'h3F2F;
      8'h29: plain_c = 8'h20;   8'h5A: plain_c = 8'h0D;   8'h66: plain_c = 8'h7F;
      8'h0D: plain_c = 8'h09;   8'h76: plain_c = 8'h1B;
      8'h05: fkey_c = 8'h50;    8'h06: fkey_c = 8'h51;
      8'h04: fkey_c = 8'h52;    8'h0C: fkey_c = 8'h53;
      8'h75: ext_c = 8'h41;     8'h72: ext_c = 8'h42;     8'h74: ext_c = 8'h43;
      8'h6B: ext_c = 8'h44;     8'h6C: ext_c = 8'h48;     8'h69: ext_c = 8'h46;
      default: letter_c = 8'h00;
    endcase
  end

  // Modifier resolution: ctrl wins on letters; caps only affects letters
  always_comb begin
    single_chr = 8'h00;
    if (letter_c != 8'h00) begin
      if (ctrl_q)                 single_chr = letter_c & 8'h1F;
      else if (shift_q ^ caps_q)  single_chr = letter_c & 8'hDF;
      else                        single_chr = letter_c;
    end else if (sym_c != 16'h0000) begin
      single_chr = shift_q ? sym_c[15:8] : sym_c[7:0];
    end else begin
      single_chr = plain_c;
    end
  end

  assign write_c = (state_q == S_EMIT) && !fifoFull;

  // Next-state, modifier, entry and drop-counter logic
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    ctrl_d  = ctrl_q;
    caps_d  = caps_q;
    entry_d = entry_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        if (scanValid) begin
          if (scanCode == SC_E0) begin
            state_d = S_EXT;
          end else if (scanCode == SC_F0) begin
            state_d = S_BRK;
          end else if (scanCode == SC_LSHIFT || scanCode == SC_RSHIFT) begin
            shift_d = 1'b1;
          end else if (scanCode == SC_CTRL) begin
            ctrl_d = 1'b1;
          end else if (scanCode == SC_CAPS) begin
            caps_d = !caps_q;
          end else if (single_chr != 8'h00) begin
            entry_d = {8'd1, single_chr, 48'h0};
            state_d = S_EMIT;
          end else if (fkey_c != 8'h00) begin
            entry_d = {8'd3, fkey_c, 8'h4F, 8'h1B, 32'h0};
            state_d = S_EMIT;
          end
        end
      end
      S_EXT: begin
        if (scanValid) begin
          state_d = S_IDLE;
          if (scanCode == SC_F0) begin
            state_d = S_EXT_BRK;
          end else if (scanCode == SC_CTRL) begin
            ctrl_d = 1'b1;
          end else if (scanCode == SC_DEL) begin
            entry_d = {8'd4, 8'h7E, 8'h33, 8'h5B, 8'h1B, 24'h0};
            state_d = S_EMIT;
          end else if (ext_c != 8'h00) begin
            entry_d = {8'd3, ext_c, 8'h5B, 8'h1B, 32'h0};
            state_d = S_EMIT;
          end
        end
      end
      S_BRK: begin
        if (scanValid) begin
          state_d = S_IDLE;
          if (scanCode == SC_LSHIFT || scanCode == SC_RSHIFT) shift_d = 1'b0;
          if (scanCode == SC_CTRL)                            ctrl_d  = 1'b0;
        end
      end
      S_EXT_BRK: begin
        // Only right-ctrl release matters; the fake-shift release is ignored
        if (scanValid) begin
          state_d = S_IDLE;
          if (scanCode == SC_CTRL) ctrl_d = 1'b0;
        end
      end
      S_EMIT: begin
        // A byte arriving while an entry waits is lost; the parser restarts in IDLE
        if (scanValid && drop_q != DROP_MAX) drop_d = drop_q + DROP_CNT_W'(1);
        if (write_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      caps_q  <= 1'b0;
      entry_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      ctrl_q  <= ctrl_d;
      caps_q  <= caps_d;
      entry_q <= entry_d;
      drop_q  <= drop_d;
    end
  end

  assign fifoWriteRequest = write_c;
  assign fifoInData       = entry_q;
  assign capsLed          = caps_q;
  assign droppedCount     = drop_q;

endmodule

// File: tb/tb_keycode_packer.sv
// Bench for keycode_packer: stimulus tasks run a key-level reference model
// and queue the expected entries and write cycles; a negedge monitor pops
// and compares whenever the DUT strobes a write.
module tb_keycode_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        scanValid;
  logic [7:0]  scanCode;
  logic        fifoFull;
  logic        fifoWriteRequest;
  logic [63:0] fifoInData;
  logic        capsLed;
  logic [7:0]  droppedCount;

  keycode_packer #(.DROP_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .scanValid(scanValid), .scanCode(scanCode),
    .fifoFull(fifoFull), .fifoWriteRequest(fifoWriteRequest),
    .fifoInData(fifoInData), .capsLed(capsLed), .droppedCount(droppedCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  int          cyc_q[$];
  logic [7:0]  pfx[$];
  logic [7:0]  m_seq[$];
  bit          m_shift, m_ctrl, m_caps, m_pending;
  logic [7:0]  m_drop;
  bit          exp_caps;
  logic [7:0]  exp_drop;

  logic [7:0] let_codes [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] sym_codes [0:20] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
    8'h41, 8'h49, 8'h4A};
  logic [7:0] sym_lo [0:20] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
    8'h38, 8'h39, 8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
    8'h2C, 8'h2E, 8'h2F};
  logic [7:0] sym_hi [0:20] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
    8'h2A, 8'h28, 8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
    8'h3C, 8'h3E, 8'h3F};
  logic [7:0] misc_codes [0:14] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h12, 8'h59,
    8'h14, 8'h58, 8'h05, 8'h06, 8'h04, 8'h0C, 8'h77, 8'h7E};
  logic [7:0] ext_codes [0:8] = '{8'h75, 8'h72, 8'h74, 8'h6B, 8'h6C, 8'h69, 8'h71,
    8'h12, 8'h14};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First byte of the sequence lands in char[len], last in char1
  function automatic logic [63:0] pack();
    logic [63:0] r;
    int n;
    r = '0;
    n = m_seq.size();
    r[63:56] = 8'(n);
    for (int j = 0; j < n; j++) r[63-8*(n-j) -: 8] = m_seq[j];
    return r;
  endfunction

  // Byte sequence a completed make code produces (empty if unmapped)
  function automatic void lookup(input bit ext, input logic [7:0] code);
    m_seq.delete();
    if (ext) begin
      case (code)
        8'h75: m_seq = '{8'h1B, 8'h5B, 8'h41};
        8'h72: m_seq = '{8'h1B, 8'h5B, 8'h42};
        8'h74: m_seq = '{8'h1B, 8'h5B, 8'h43};
        8'h6B: m_seq = '{8'h1B, 8'h5B, 8'h44};
        8'h6C: m_seq = '{8'h1B, 8'h5B, 8'h48};
        8'h69: m_seq = '{8'h1B, 8'h5B, 8'h46};
        8'h71: m_seq = '{8'h1B, 8'h5B, 8'h33, 8'h7E};
        default: ;
      endcase
      return;
    end
    for (int i = 0; i < 26; i++) begin
      if (let_codes[i] == code) begin
        logic [7:0] ch;
        ch = 8'h61 + 8'(i);
        if (m_ctrl) ch = ch - 8'h60;
        else if (m_shift != m_caps) ch = ch - 8'h20;
        m_seq.push_back(ch);
        return;
      end
    end
    for (int i = 0; i < 21; i++) begin
      if (sym_codes[i] == code) begin
        m_seq.push_back(m_shift ? sym_hi[i] : sym_lo[i]);
        return;
      end
    end
    case (code)
      8'h29: m_seq = '{8'h20};
      8'h5A: m_seq = '{8'h0D};
      8'h66: m_seq = '{8'h7F};
      8'h0D: m_seq = '{8'h09};
      8'h76: m_seq = '{8'h1B};
      8'h05: m_seq = '{8'h1B, 8'h4F, 8'h50};
      8'h06: m_seq = '{8'h1B, 8'h4F, 8'h51};
      8'h04: m_seq = '{8'h1B, 8'h4F, 8'h52};
      8'h0C: m_seq = '{8'h1B, 8'h4F, 8'h53};
      default: ;
    endcase
  endfunction

  // Key-level parse: collect prefixes, then act on the completed key
  function automatic void parse(input logic [7:0] code);
    bit ext, brk;
    if (code == 8'hE0 && pfx.size() == 0) begin pfx.push_back(code); return; end
    if (code == 8'hF0 && (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0))) begin
      pfx.push_back(code);
      return;
    end
    ext = 0;
    brk = 0;
    foreach (pfx[i]) begin
      if (pfx[i] == 8'hE0) ext = 1;
      if (pfx[i] == 8'hF0) brk = 1;
    end
    pfx.delete();
    if (brk) begin
      if (!ext && (code == 8'h12 || code == 8'h59)) m_shift = 0;
      if (code == 8'h14) m_ctrl = 0;
      return;
    end
    if (!ext && (code == 8'h12 || code == 8'h59)) m_shift = 1;
    else if (code == 8'h14) m_ctrl = 1;
    else if (!ext && code == 8'h58) m_caps = !m_caps;
    else if (!(ext && code == 8'h12)) begin
      lookup(ext, code);
      if (m_seq.size() > 0) begin
        exp_q.push_back(pack());
        m_pending = 1;
      end
    end
  endfunction

  // One clock interval of stimulus plus the matching model step
  task automatic step(input bit v, input logic [7:0] code, input bit full);
    @(posedge clk);
    #1;
    rst = 0;
    scanValid = v;
    scanCode = code;
    fifoFull = full;
    exp_caps = m_caps;
    exp_drop = m_drop;
    if (m_pending) begin
      if (v && m_drop != 8'hFF) m_drop++;
      if (!full) begin
        cyc_q.push_back(cyc);
        m_pending = 0;
      end
    end else if (v) begin
      parse(code);
    end
  endtask

  task automatic send(input logic [7:0] code);
    step(1, code, 0);
    step(0, 8'h00, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    scanValid = 0;
    fifoFull = 0;
    m_shift = 0; m_ctrl = 0; m_caps = 0; m_pending = 0; m_drop = 8'h00;
    pfx.delete();
    exp_q.delete();
    cyc_q.delete();
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 11))
      0, 1, 2: return let_codes[$urandom_range(0, 25)];
      3, 4:    return sym_codes[$urandom_range(0, 20)];
      5, 6:    return misc_codes[$urandom_range(0, 14)];
      7:       return 8'hE0;
      8:       return 8'hF0;
      9, 10:   return ext_codes[$urandom_range(0, 8)];
      default: return 8'($urandom);
    endcase
  endfunction

  // Monitor: continuous status checks plus scoreboard pop on each write
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("caps_led", 64'(capsLed), 64'(exp_caps));
      chk("dropped_count", 64'(droppedCount), 64'(exp_drop));
      if (fifoWriteRequest) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(1), 64'(0));
        end else begin
          chk("entry_data", fifoInData, exp_q.pop_front());
          if (cyc_q.size() == 0) chk("write_early", 64'(cyc), 64'(-1));
          else chk("write_cycle", 64'(cyc), 64'(cyc_q.pop_front()));
        end
      end else if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
        chk("write_missing", 64'(0), 64'(1));
        void'(cyc_q.pop_front());
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1;
    scanValid = 0;
    scanCode = 8'h00;
    fifoFull = 0;
    exp_caps = 0;
    exp_drop = 8'h00;
    do_reset();
    mon_en = 1;
    step(0, 8'h00, 0);
    chk("reset_data", fifoInData, 64'h0);
    chk("reset_wr", 64'(fifoWriteRequest), 64'(0));

    // Plain 'a', shift/break, caps and ctrl-A
    send(8'h1C);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    send(8'h58);
    chk("caps_on", 64'(capsLed), 64'(1));
    send(8'h1C); send(8'h14); send(8'h1C);
    send(8'hF0); send(8'h14); send(8'h58);
    chk("caps_off", 64'(capsLed), 64'(0));

    // Escapes: Up, Delete, F1, fake shift ignored
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h71);
    send(8'h05);
    send(8'hE0); send(8'h12); send(8'h16);

    // Blocked FIFO: five drops, then one write once released
    step(1, 8'h1C, 1);
    for (int i = 0; i < 5; i++) step(1, 8'h32, 1);
    step(0, 8'h00, 1);
    chk("drop5", 64'(droppedCount), 64'(5));
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    // Saturation after 300 more drops
    step(1, 8'h1C, 1);
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("drop_sat", 64'(droppedCount), 64'(8'hFF));

    // Lone F0 discarded by reset
    send(8'hF0);
    do_reset();
    step(0, 8'h00, 0);
    chk("reset_data2", fifoInData, 64'h0);
    chk("reset_drop", 64'(droppedCount), 64'(0));
    send(8'h1C);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 9) < 6), pick(), ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 10; i++) step(0, 8'h00, 0);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
